register_file_sb: RTL and testbench

REGISTER_FILE_SB -- requirements
Module: register_file_sb

---
 rtl/register_file_sb.sv | 130 +++++++++++++
 tb/tb_register_file_sb.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// register_file_sb
//   Register file with two registered read ports, one write port and a
//   per-register pending (scoreboard) bit. Issuing an instruction marks its
//   destination pending; the write that retires it clears the bit again.
//
//   Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
//   data to a read port whose address matches the write address. With the
//   macro undefined, a read in the write cycle returns the pre-write value.
//
// Parameters
//   DATA_W   register / data port width
//   ADDR_W   register address width (DEPTH = 2**ADDR_W registers)
//   ZERO_REG 1 = register 0 hardwired to zero and never pending
//
// Ports
//   clock        single clock, all state on rising edge
//   reset        synchronous, active-high; clears registers, outputs, pending
//   regWrite     write enable
//   writeReg     write address
//   dataToWrite  write data
//   reg1, reg2   read addresses for ports 1 / 2
//   data1, data2 registered read data (1-cycle latency)
//   issueValid   instruction issued; issueReg becomes pending
//   issueReg     destination register of the issued instruction
//   busy1, busy2 registered pending flag of reg1 / reg2, post-update
//   pendingMask  current pending state, bit i = register i
module register_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   regWrite,
  input  logic [ADDR_W-1:0]      writeReg,
  input  logic [DATA_W-1:0]      dataToWrite,
  input  logic [ADDR_W-1:0]      reg1,
  input  logic [ADDR_W-1:0]      reg2,
  output logic [DATA_W-1:0]      data1,
  output logic [DATA_W-1:0]      data2,
  input  logic                   issueValid,
  input  logic [ADDR_W-1:0]      issueReg,
  output logic                   busy1,
  output logic                   busy2,
  output logic [2**ADDR_W-1:0]   pendingMask
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0]  pend_reg;
  logic [DEPTH-1:0]  pend_next;

  logic [DATA_W-1:0] data1_reg, data1_next;
  logic [DATA_W-1:0] data2_reg, data2_next;
  logic              busy1_reg, busy1_next;
  logic              busy2_reg, busy2_next;

  logic wr_zero;
  logic wr_ok;
  logic rd1_zero;
  logic rd2_zero;

  // Writes aimed at a hardwired-zero register 0 are dropped entirely, which
  // also keeps them out of the bypass path.
  assign wr_zero  = (ZERO_REG != 0) && (writeReg == '0);
  assign wr_ok    = regWrite && !wr_zero;
  assign rd1_zero = (ZERO_REG != 0) && (reg1 == '0);
  assign rd2_zero = (ZERO_REG != 0) && (reg2 == '0);

  // Pending update per register: issue wins over a same-cycle clear so a
  // back-to-back producer keeps its destination marked busy.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign pend_next[gi] = 1'b0;
      end else begin : g_norm
        always_comb begin
          pend_next[gi] = pend_reg[gi];
          if (regWrite && (writeReg == ADDR_W'(gi)))
            pend_next[gi] = 1'b0;
          if (issueValid && (issueReg == ADDR_W'(gi)))
            pend_next[gi] = 1'b1;
        end
      end
    end
  endgenerate

  // Read data selection for both ports.
  always_comb begin
    data1_next = rd1_zero ? '0 : regs_reg[reg1];
    data2_next = rd2_zero ? '0 : regs_reg[reg2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (writeReg == reg1))
      data1_next = dataToWrite;
    if (wr_ok && (writeReg == reg2))
      data2_next = dataToWrite;
`endif
    // Busy reports the state after this edge's set/clear.
    busy1_next = pend_next[reg1];
    busy2_next = pend_next[reg2];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs_reg[i] <= '0;
      pend_reg  <= '0;
      data1_reg <= '0;
      data2_reg <= '0;
      busy1_reg <= 1'b0;
      busy2_reg <= 1'b0;
    end else begin
      if (wr_ok)
        regs_reg[writeReg] <= dataToWrite;
      pend_reg  <= pend_next;
      data1_reg <= data1_next;
      data2_reg <= data2_next;
      busy1_reg <= busy1_next;
      busy2_reg <= busy2_next;
    end
  end

  assign data1       = data1_reg;
  assign data2       = data2_reg;
  assign busy1       = busy1_reg;
  assign busy2       = busy2_reg;
  assign pendingMask = pend_reg;

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] dataToWrite;
  logic [AW-1:0] reg1, reg2;
  logic          issueValid;
  logic [AW-1:0] issueReg;

  logic [DW-1:0] data1_a, data2_a, data1_b, data2_b;
  logic          busy1_a, busy2_a, busy1_b, busy2_b;
  logic [N-1:0]  mask_a, mask_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: instance 0 has an ordinary r0, instance 1 a zero r0.
  logic [DW-1:0] mdl_mem  [2][N];
  logic [N-1:0]  mdl_pend [2];
  logic [DW-1:0] e_d1 [2];
  logic [DW-1:0] e_d2 [2];
  logic          e_b1 [2];
  logic          e_b2 [2];

  always #5 clock = ~clock;

  register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut_a (
    .clock(clock), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
    .dataToWrite(dataToWrite), .reg1(reg1), .reg2(reg2),
    .data1(data1_a), .data2(data2_a), .issueValid(issueValid),
    .issueReg(issueReg), .busy1(busy1_a), .busy2(busy2_a),
    .pendingMask(mask_a)
  );

  register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut_b (
    .clock(clock), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
    .dataToWrite(dataToWrite), .reg1(reg1), .reg2(reg2),
    .data1(data1_b), .data2(data2_b), .issueValid(issueValid),
    .issueReg(issueReg), .busy1(busy1_b), .busy2(busy2_b),
    .pendingMask(mask_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the reference, compare all outputs.
  task automatic step(input logic rst, input logic we, input int wa, input logic [DW-1:0] wd,
                      input logic iv, input int ia, input int r1, input int r2);
    bit bypass;
    bit zr;
`ifdef REGFILE_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    reset = rst; regWrite = we; writeReg = AW'(wa); dataToWrite = wd;
    issueValid = iv; issueReg = AW'(ia); reg1 = AW'(r1); reg2 = AW'(r2);
    for (int k = 0; k < 2; k++) begin
      zr = (k == 1);
      if (rst) begin
        for (int i = 0; i < N; i++) mdl_mem[k][i] = '0;
        mdl_pend[k] = '0;
        e_d1[k] = '0; e_d2[k] = '0; e_b1[k] = 1'b0; e_b2[k] = 1'b0;
      end else begin
        bit wvalid;
        wvalid = we && !(zr && wa == 0);
        e_d1[k] = (zr && r1 == 0) ? '0 : mdl_mem[k][r1];
        e_d2[k] = (zr && r2 == 0) ? '0 : mdl_mem[k][r2];
        if (bypass && wvalid && wa == r1) e_d1[k] = wd;
        if (bypass && wvalid && wa == r2) e_d2[k] = wd;
        if (wvalid) mdl_mem[k][wa] = wd;
        if (we) mdl_pend[k][wa] = 1'b0;
        if (iv) mdl_pend[k][ia] = 1'b1;
        if (zr) mdl_pend[k][0] = 1'b0;
        e_b1[k] = mdl_pend[k][r1];
        e_b2[k] = mdl_pend[k][r2];
      end
    end
    @(posedge clock);
    #1;
    check("a.data1", 32'(data1_a), 32'(e_d1[0]));
    check("a.data2", 32'(data2_a), 32'(e_d2[0]));
    check("a.busy1", 32'(busy1_a), 32'(e_b1[0]));
    check("a.busy2", 32'(busy2_a), 32'(e_b2[0]));
    check("a.mask",  32'(mask_a),  32'(mdl_pend[0]));
    check("b.data1", 32'(data1_b), 32'(e_d1[1]));
    check("b.data2", 32'(data2_b), 32'(e_d2[1]));
    check("b.busy1", 32'(busy1_b), 32'(e_b1[1]));
    check("b.busy2", 32'(busy2_b), 32'(e_b2[1]));
    check("b.mask",  32'(mask_b),  32'(mdl_pend[1]));
  endtask

  // idle cycle with reads only
  task automatic rd(input int r1, input int r2);
    step(1'b0, 1'b0, 0, '0, 1'b0, 0, r1, r2);
  endtask

  initial begin
    logic [DW-1:0] exp35;
    reset = 1'b1; regWrite = 1'b0; writeReg = '0; dataToWrite = '0;
    issueValid = 1'b0; issueReg = '0; reg1 = '0; reg2 = '0;

    // Reset with a write and issue present: both must be dropped.
    step(1'b1, 1'b1, 2, 16'h1111, 1'b1, 2, 0, 0);
    check("rst.mask_a", 32'(mask_a), 32'h0);

    // All registers read zero and idle after reset.
    for (int i = 0; i < N; i++) begin
      rd(i, N - 1 - i);
      check("post_rst.data1", 32'(data1_a), 32'h0);
      check("post_rst.busy1", 32'(busy1_a), 32'h0);
    end
    check("post_rst.mask", 32'(mask_a), 32'h0);

    // Write then read next cycle.
    step(1'b0, 1'b1, 3, 16'hBEEF, 1'b0, 0, 0, 0);
    rd(3, 0);
    check("wr_rd.data1", 32'(data1_a), 32'hBEEF);

    // Same-cycle write/read: forwarded or old value depending on build.
`ifdef REGFILE_BYPASS_EN
    exp35 = 16'h1234;
`else
    exp35 = 16'h0000;
`endif
    step(1'b0, 1'b1, 5, 16'h1234, 1'b0, 0, 0, 5);
    check("same_cyc.data2", 32'(data2_a), 32'(exp35));
    rd(0, 5);
    check("after_wr.data2", 32'(data2_a), 32'h1234);

    // Issue r2, two cycles later write r2 together with a new issue of r2.
    step(1'b0, 1'b0, 0, '0, 1'b1, 2, 2, 0);
    check("issue.busy1", 32'(busy1_a), 32'h1);
    rd(2, 0);
    step(1'b0, 1'b1, 2, 16'h00AA, 1'b1, 2, 2, 2);
    check("wr_issue.mask2", 32'(mask_a[2]), 32'h1);
    rd(2, 2);
    check("wr_issue.data", 32'(data1_a), 32'h00AA);
    // Write and issue to different registers: one clears, one sets.
    step(1'b0, 1'b1, 2, 16'h0BB0, 1'b1, 7, 2, 7);
    check("diff.mask", 32'(mask_a), 32'h80);

    // Zero register: write r0 and issue r0.
    step(1'b0, 1'b1, 0, 16'hFFFF, 1'b1, 0, 0, 0);
    rd(0, 0);
    check("zr.data1", 32'(data1_b), 32'h0);
    check("zr.mask0", 32'(mask_b[0]), 32'h0);
    check("nz.data1", 32'(data1_a), 32'hFFFF);
    check("nz.mask0", 32'(mask_a[0]), 32'h1);

    // Pending bits then a reset colliding with a write.
    step(1'b0, 1'b0, 0, '0, 1'b1, 1, 0, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, 4, 0, 0);
    step(1'b0, 1'b0, 0, '0, 1'b1, 6, 0, 0);
    step(1'b1, 1'b1, 4, 16'h5555, 1'b0, 0, 4, 4);
    check("midrst.mask", 32'(mask_a), 32'h0);
    rd(4, 4);
    check("midrst.r4", 32'(data1_a), 32'h0);

    // Randomized traffic against the reference.
    for (int t = 0; t < 400; t++) begin
      step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, N - 1)), DW'($urandom),
           1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
           int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
